// File: rtl/alu_control_decoder.sv
// rtl/alu_control_decoder.sv - registered ALUOp/Funct to ALUControl decoder with illegal-funct counter
module alu_control_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  output logic             out_valid,
  output logic [2:0]       ALUControl,
  output logic             illegal_funct,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  logic [2:0] dec_ctrl;
  logic       dec_illegal;
  logic       cnt_sat;

  always_comb begin
    dec_ctrl    = CTL_ADD;
    dec_illegal = 1'b0;
    case (ALUOp)
      2'b00: dec_ctrl = CTL_ADD;
      2'b01: dec_ctrl = CTL_SUB;
      default: begin
        // ALUOp 10 and 11 both select the R-type funct decode
        case (Funct)
          6'b100000: dec_ctrl = CTL_ADD;
          6'b100010: dec_ctrl = CTL_SUB;
          6'b100100: dec_ctrl = CTL_AND;
          6'b100101: dec_ctrl = CTL_OR;
          6'b101010: dec_ctrl = CTL_SLT;
          default: begin
            dec_ctrl    = CTL_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign cnt_sat = &illegal_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      ALUControl    <= CTL_ADD;
      illegal_funct <= 1'b0;
      illegal_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALUControl    <= dec_ctrl;
        illegal_funct <= dec_illegal;
        if (dec_illegal && !cnt_sat) begin
          illegal_count <= illegal_count + 1'b1;
        end
      end else begin
        illegal_funct <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_decoder.sv
// tb/tb_alu_control_decoder.sv - scoreboard bench for alu_control_decoder
module tb_alu_control_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       out_valid;
  logic [2:0] ALUControl;
  logic       illegal_funct;
  logic [7:0] illegal_count;

  alu_control_decoder #(.CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .ALUOp(ALUOp),
    .Funct(Funct),
    .out_valid(out_valid),
    .ALUControl(ALUControl),
    .illegal_funct(illegal_funct),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       valid;
    logic [2:0] ctrl;
    logic       ill;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] m_ctrl = 3'b010;
  logic [7:0] m_cnt = 8'd0;

  // Monitor: one slot per clock, checked 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: slot missed (due %0d, now %0d)", e.name, e.due, cyc);
      end else if (out_valid !== e.valid || ALUControl !== e.ctrl ||
                   illegal_funct !== e.ill || illegal_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got valid=%b ctrl=%b ill=%b cnt=%0d, want valid=%b ctrl=%b ill=%b cnt=%0d",
                 e.name, out_valid, ALUControl, illegal_funct, illegal_count,
                 e.valid, e.ctrl, e.ill, e.cnt);
      end
    end
  end

  task automatic step(input string name, input logic r, input logic v,
                      input logic [1:0] op, input logic [5:0] fn,
                      input logic [2:0] ec, input logic ei);
    exp_t e;
    @(negedge clk);
    reset    = r;
    in_valid = v;
    ALUOp    = op;
    Funct    = fn;
    if (r) begin
      m_ctrl = 3'b010;
      m_cnt  = 8'd0;
      e.valid = 1'b0;
      e.ill   = 1'b0;
    end else begin
      if (v) begin
        m_ctrl = ec;
        if (ei && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
      end
      e.valid = v;
      e.ill   = v & ei;
    end
    e.ctrl = m_ctrl;
    e.cnt  = m_cnt;
    e.name = name;
    e.due  = cyc + 1;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, queue=%0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    step("reset0", 1, 0, 2'b00, 6'b000000, 3'b010, 0);
    step("reset1", 1, 0, 2'b00, 6'b000000, 3'b010, 0);
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 2'b10, 6'b000000, 3'b000, 0);

    step("lw_add", 0, 1, 2'b00, 6'b101010, 3'b010, 0);
    step("beq_sub", 0, 1, 2'b01, 6'b100100, 3'b110, 0);
    step("hold_ctrl", 0, 0, 2'b10, 6'b100100, 3'b000, 0);

    for (int k = 0; k < 2; k++) begin
      logic [1:0] op;
      op = (k == 0) ? 2'b10 : 2'b11;
      step("r_add", 0, 1, op, 6'b100000, 3'b010, 0);
      step("r_sub", 0, 1, op, 6'b100010, 3'b110, 0);
      step("r_and", 0, 1, op, 6'b100100, 3'b000, 0);
      step("r_or",  0, 1, op, 6'b100101, 3'b001, 0);
      step("r_slt", 0, 1, op, 6'b101010, 3'b111, 0);
    end

    step("ill_000000", 0, 1, 2'b10, 6'b000000, 3'b010, 1);
    step("ill_001000", 0, 1, 2'b10, 6'b001000, 3'b010, 1);
    step("idle_ill_clr", 0, 0, 2'b10, 6'b001000, 3'b000, 0);
    step("mem_000000", 0, 1, 2'b00, 6'b000000, 3'b010, 0);
    step("mem_001000", 0, 1, 2'b00, 6'b001000, 3'b010, 0);
    step("slt_after_ill", 0, 1, 2'b11, 6'b101010, 3'b111, 0);

    for (int i = 0; i < 300; i++) step("sat_ill", 0, 1, 2'b10, 6'b111111, 3'b010, 1);
    step("sat_legal", 0, 1, 2'b10, 6'b100010, 3'b110, 0);
    step("sat_idle", 0, 0, 2'b00, 6'b000000, 3'b000, 0);

    step("rst_prio", 1, 1, 2'b10, 6'b000001, 3'b010, 1);
    step("post_rst_or", 0, 1, 2'b10, 6'b100101, 3'b001, 0);
    step("post_rst_ill", 0, 1, 2'b11, 6'b000011, 3'b010, 1);
    step("mid_rst", 1, 0, 2'b00, 6'b000000, 3'b010, 0);
    step("tail_idle", 0, 0, 2'b00, 6'b000000, 3'b000, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_decoder.md
Name: alu_control_decoder

Overview:
- Main-decoder companion for the single-cycle/pipelined MIPS datapath.
- Translates the 2-bit ALUOp from the control unit and the 6-bit R-type Funct field into the 3-bit ALUControl code that drives the ALU.
- Outputs are registered, so there is one cycle of latency.
- Also flags unsupported Funct encodings and keeps a saturating count of them for debug.

Parameters:
- CNT_W, 8, width of the illegal-funct event counter.

Ports:
- Interface: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ALUOp/Funct are meaningful this cycle.
- ALUOp  input  2  operation class from the main control unit.
- Funct  input  6  instruction bits [5:0].
- out_valid  output  1  registered copy of in_valid.
- ALUControl  output  3  registered ALU operation code.
- illegal_funct  output  1  registered; the accepted R-type Funct was unsupported.
- illegal_count  output  CNT_W  saturating count of illegal_funct events.

Behaviour:
- ALUControl encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. Other codes are never produced.
- Combinational decode of the next value:
  - ALUOp=00 -> 010 (lw/sw address add); Funct ignored.
  - ALUOp=01 -> 110 (beq subtract); Funct ignored.
  - ALUOp=10 or 11 -> decode Funct:
    - 100000 add -> 010
    - 100010 sub -> 110
    - 100100 and -> 000
    - 100101 or -> 001
    - 101010 slt -> 111
  - Any other Funct with ALUOp=1x -> ALUControl 010 and illegal asserted.
- Register update on each rising clk edge when reset=0:
  - out_valid <= in_valid.
  - If in_valid=1: ALUControl <= decoded value; illegal_funct <= decoded illegal.
  - If in_valid=0: ALUControl holds its previous value; illegal_funct <= 0.
- illegal_count:
  - Increments by 1 on each edge where in_valid=1 and the decoded illegal=1.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Latency: inputs presented in cycle N appear on the outputs after edge N+1. Back-to-back valid inputs are accepted every cycle; there is no backpressure.
- Reset (synchronous, active-high) loads: out_valid=0, ALUControl=010, illegal_funct=0, illegal_count=0.
  - Reset takes priority over in_valid in the same cycle; that input is discarded and is not counted.
  - Reset asserted mid-stream clears everything on the next edge.
- X/unknown inputs are not permitted when in_valid=1. ALUOp=11 is decoded identically to 10.
- No internal combinational path from inputs to outputs.

Test Plan:
- Reset then idle: assert reset for 2 cycles -> out_valid=0, ALUControl=010, illegal_funct=0, illegal_count=0. Hold in_valid=0 afterwards -> outputs unchanged.
- Memory/branch classes:
  - in_valid=1, ALUOp=00, Funct=101010 -> next cycle ALUControl=010, illegal_funct=0.
  - ALUOp=01, Funct=100100 -> next cycle ALUControl=110.
- R-type sweep, back-to-back with ALUOp=10:
  - Funct 100000, 100010, 100100, 100101, 101010 on consecutive cycles -> ALUControl 010, 110, 000, 001, 111 on the following consecutive cycles, out_valid=1 throughout.
  - Repeat with ALUOp=11 -> identical results.
- Illegal funct: ALUOp=10, Funct=000000 then 001000 -> ALUControl=010 with illegal_funct=1 for both cycles, illegal_count=2. The same Funct values with ALUOp=00 give illegal_funct=0 and no count change.
- Counter saturation (CNT_W=8): 300 consecutive illegal R-type inputs -> illegal_count stops at 255. A following legal input leaves it at 255.
- Reset priority: reset=1 together with in_valid=1, ALUOp=10, Funct=000001 -> next cycle out_valid=0, ALUControl=010, illegal_count=0 (the input is not counted).
